// File: rtl/game_pkg.sv
// Shared display geometry, colours, scanner state encoding and pixel indexing
// used by game_state and frame_scanner.
package game_pkg;

    localparam int unsigned DISP_COLS = 16;
    localparam int unsigned DISP_ROWS = 32;
    localparam int unsigned DISP_BITS = 512;

    localparam logic [2:0] COLOUR_FG = 3'b111;
    localparam logic [2:0] COLOUR_BG = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Pixel (x,y) lives at bit 32*x + y of the bitmap.
    function automatic logic [8:0] pix_index(input logic [3:0] px, input logic [4:0] py);
        return {px, py};
    endfunction

endpackage

// File: rtl/frame_scanner_scan_counter.sv
// Cascaded x/y pixel counter: y is the inner (fast) axis, x the outer one.
module scan_counter
    import game_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic [3:0] cx_o,
    output logic [4:0] cy_o,
    output logic       last_o
);

    logic [3:0] cx_q;
    logic [4:0] cy_q;

    // Advance one pixel per enabled cycle; clear wins over enable.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cx_q <= 4'd0;
            cy_q <= 5'd0;
        end else if (clear_i) begin
            cx_q <= 4'd0;
            cy_q <= 5'd0;
        end else if (enable_i) begin
            if (cy_q == 5'(DISP_ROWS - 1)) begin
                cy_q <= 5'd0;
                cx_q <= cx_q + 4'd1;
            end else begin
                cy_q <= cy_q + 5'd1;
            end
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == 4'(DISP_COLS - 1)) && (cy_q == 5'(DISP_ROWS - 1));

endmodule

// File: rtl/frame_scanner.sv
// Snapshots the display bitmap on each frame tick and streams it to the VGA plot port.
// Define FRAME_SCANNER_DIFF_EN to plot only pixels that changed since the last scan.
module frame_scanner
    import game_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    input  logic         frame_tick,
    input  logic [511:0] display,
    output logic [3:0]   x,
    output logic [4:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun
);

    scan_state_t          state_q;
    logic [DISP_BITS-1:0] shadow_q;
    logic                 pending_q;
    logic                 overrun_q;
    logic [3:0]           x_q;
    logic [4:0]           y_q;
    logic [2:0]           colour_q;
    logic                 plot_q;
    logic                 busy_q;
    logic                 done_q;

    logic [3:0] cx_s;
    logic [4:0] cy_s;
    logic       last_s;
    logic       start_s;
    logic       cnt_en_s;
    logic [8:0] idx_s;
    logic       pix_bit_s;
    logic       plot_next_s;

`ifdef FRAME_SCANNER_DIFF_EN
    logic [DISP_BITS-1:0] last_drawn_q;
    logic                 force_all_q;
`endif

    scan_counter u_scan_counter (
        .clock    (clock),
        .resetn   (resetn),
        .clear_i  (start_s),
        .enable_i (cnt_en_s),
        .cx_o     (cx_s),
        .cy_o     (cy_s),
        .last_o   (last_s)
    );

    // Start decode, current pixel lookup and plot qualification.
    always_comb begin
        start_s     = 1'b0;
        cnt_en_s    = 1'b0;
        idx_s       = pix_index(cx_s, cy_s);
        pix_bit_s   = shadow_q[idx_s];
        plot_next_s = 1'b1;
        if ((state_q != SCAN) && (frame_tick || pending_q)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if (state_q == SCAN) begin
            cnt_en_s = 1'b1;
        end else begin
            cnt_en_s = 1'b0;
        end
`ifdef FRAME_SCANNER_DIFF_EN
        plot_next_s = force_all_q | (pix_bit_s ^ last_drawn_q[idx_s]);
`endif
    end

    // Scanner FSM with registered VGA-side outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            x_q       <= 4'd0;
            y_q       <= 5'd0;
            colour_q  <= COLOUR_BG;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    if (start_s) begin
                        shadow_q  <= display;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    x_q      <= cx_s;
                    y_q      <= cy_s;
                    colour_q <= pix_bit_s ? COLOUR_FG : COLOUR_BG;
                    plot_q   <= plot_next_s;
                    if (frame_tick) begin
                        if (pending_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            pending_q <= 1'b1;
                        end
                    end
                    if (last_s) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b1;
                    // A held request plus a fresh tick: one restarts, the other is lost.
                    if (start_s) begin
                        shadow_q  <= display;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= SCAN;
                        if (frame_tick && pending_q) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_SCANNER_DIFF_EN
    // Remember what the framebuffer holds; the first scan after reset draws everything.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_drawn_q <= '0;
            force_all_q  <= 1'b1;
        end else begin
            if (state_q == SCAN) begin
                last_drawn_q[idx_s] <= pix_bit_s;
            end
            if (state_q == DONE) begin
                force_all_q <= 1'b0;
            end
        end
    end
`endif

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_scanner.sv
// Self-checking bench for frame_scanner: frame-level reference model plus directed
// and randomized tick/display/reset stimulus.
module tb_frame_scanner;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         frame_tick = 1'b0;
    logic [511:0] display = '0;
    logic [3:0]   x;
    logic [4:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    frame_scanner dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .display    (display),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame position counts edges since the snapshot edge (-1 = idle).
    int           m_pos = -1;
    logic [511:0] m_snap = '0;
    logic [511:0] m_last = '0;
    bit           m_force = 1'b1;
    bit           m_pend = 1'b0;
    bit           m_ovr = 1'b0;
    logic [3:0]   e_x = 4'd0;
    logic [4:0]   e_y = 5'd0;
    logic [2:0]   e_col = 3'd0;
    logic         e_plot = 1'b0;
    logic         e_busy = 1'b0;
    logic         e_done = 1'b0;

    // Observation tallies.
    int gcyc = 0;
    int t0 = 0;
    int n_plot = 0;
    int n_fg = 0;
    int n_done = 0;
    int fg_at = -1;
    int done_at = -1;
    int first_plot_at = -1;
    logic [3:0] fg_x = 4'd0;
    logic [4:0] fg_y = 5'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_start();
        m_snap = display;
        m_pos  = 0;
        m_pend = 1'b0;
        e_busy = 1'b1;
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_pos = -1; m_snap = '0; m_last = '0; m_force = 1'b1;
            m_pend = 1'b0; m_ovr = 1'b0;
            e_x = 4'd0; e_y = 5'd0; e_col = 3'b000;
            e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_pos < 0) begin
                e_plot = 1'b0;
                if (frame_tick) model_start();
            end else if (m_pos < 512) begin
                e_x   = 4'(m_pos / 32);
                e_y   = 5'(m_pos % 32);
                e_col = m_snap[m_pos] ? 3'b111 : 3'b000;
`ifdef FRAME_SCANNER_DIFF_EN
                e_plot = m_force || (m_snap[m_pos] != m_last[m_pos]);
                m_last[m_pos] = m_snap[m_pos];
`else
                e_plot = 1'b1;
`endif
                if (frame_tick) begin
                    if (m_pend) m_ovr = 1'b1;
                    else m_pend = 1'b1;
                end
                m_pos++;
            end else begin
                e_plot  = 1'b0;
                e_done  = 1'b1;
                m_force = 1'b0;
                if (m_pend || frame_tick) begin
                    if (m_pend && frame_tick) m_ovr = 1'b1;
                    model_start();
                end else begin
                    m_pos  = -1;
                    e_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_tally();
        n_plot = 0; n_fg = 0; n_done = 0;
        fg_at = -1; done_at = -1; first_plot_at = -1;
    endtask

    // One clock: drive, let the edge happen, advance model, compare on the falling edge.
    task automatic step(input bit tk);
        frame_tick = tk;
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("x", 32'(x), 32'(e_x));
        chk("y", 32'(y), 32'(e_y));
        chk("colour", 32'(colour), 32'(e_col));
        chk("plot", 32'(plot), 32'(e_plot));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (plot === 1'b1) begin
            n_plot++;
            if (first_plot_at < 0) first_plot_at = gcyc;
            if (colour === 3'b111) begin
                n_fg++; fg_at = gcyc; fg_x = x; fg_y = y;
            end
        end
        if (frame_done === 1'b1) begin
            n_done++; done_at = gcyc;
        end
        gcyc++;
        frame_tick = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    logic [511:0] d_save;

    initial begin
        // Reset state
        resetn = 1'b0;
        run(3);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        run(2);

        // All-zero frame: timing and plot count
        display = '0;
        clear_tally();
        t0 = gcyc;
        step(1'b1);
        run(520);
        chk("t1_first_plot", 32'(first_plot_at - t0), 32'd1);
        chk("t1_done_at", 32'(done_at - t0), 32'd513);
        chk("t1_plots", 32'(n_plot), 32'd512);
        chk("t1_fg", 32'(n_fg), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Single set pixel at (3,5)
        display = '0;
        display[32*3+5] = 1'b1;
        clear_tally();
        t0 = gcyc;
        step(1'b1);
        run(520);
        chk("t2_fg_count", 32'(n_fg), 32'd1);
        chk("t2_fg_x", 32'(fg_x), 32'd3);
        chk("t2_fg_y", 32'(fg_y), 32'd5);
        chk("t2_fg_at", 32'(fg_at - t0), 32'd102);
`ifndef FRAME_SCANNER_DIFF_EN
        chk("t2_plots", 32'(n_plot), 32'd512);
`endif

        // Display inverted mid-scan: only the snapshot is drawn
        d_save = {16{$urandom()}};
        display = d_save;
        clear_tally();
        step(1'b1);
        run(99);
        display = ~d_save;
        run(430);
`ifndef FRAME_SCANNER_DIFF_EN
        chk("t3_fg_snap", 32'(n_fg), 32'($countones(d_save)));
        clear_tally();
        step(1'b1);
        run(520);
        chk("t3_fg_next", 32'(n_fg), 32'($countones(~d_save)));
`endif

        // Pending tick restarts from DONE; second extra tick sets sticky overrun
        clear_tally();
        t0 = gcyc;
        step(1'b1);
        run(199);
        step(1'b1);
        run(99);
        step(1'b1);
        run(800);
        chk("t4_done_count", 32'(n_done), 32'd2);
        chk("t4_second_done", 32'(done_at - t0), 32'd1026);
        chk("t4_overrun", 32'(overrun), 32'd1);
`ifndef FRAME_SCANNER_DIFF_EN
        chk("t4_plots", 32'(n_plot), 32'd1024);
`endif
        run(50);
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-scan aborts the frame
        clear_tally();
        step(1'b1);
        run(50);
        resetn = 1'b0;
        step(1'b0);
        chk("t5_plot", 32'(plot), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_xy", 32'({x, y}), 32'd0);
        chk("t5_overrun", 32'(overrun), 32'd0);
        resetn = 1'b1;
        run(600);
        chk("t5_no_done", 32'(n_done), 32'd0);

        // Randomized ticks, display flips and rare resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) display[$urandom_range(0, 511)] ^= 1'b1;
            resetn = ($urandom_range(0, 2999) != 0);
            step($urandom_range(0, 299) == 0);
        end
        resetn = 1'b1;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
